// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding select encodings used by the EX-stage operand muxes
//   - divide sequencer state type
//   - default register-file address width
//   - addr_hit(): register-address match helper that never matches r0
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;

  // EX operand select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // result from WB stage
  localparam logic [1:0] FWD_MEM = 2'b10;  // result from MEM stage

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  // Addresses are zero-extended to 32 bits by the caller so one helper serves
  // every address width. r0 is hardwired to zero, so it never produces a hit.
  function automatic logic addr_hit(input logic [31:0] a, input logic [31:0] b);
    return (a != 32'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Purely combinational operand forwarding selects.
// Ports:
//   regwrite_m, regwrite_w : MEM / WB stages write the register file
//   writereg_m, writereg_w : MEM / WB destination registers
//   rs_d, rt_d             : ID source registers (branch/jr compare operands)
//   rs_e, rt_e             : EX source registers (ALU operands)
//   fwd_a_d, fwd_b_d       : ID compare operand taken from the MEM result
//   fwd_a_e, fwd_b_e       : EX operand select (FWD_RF / FWD_WB / FWD_MEM)
// -----------------------------------------------------------------------------
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic [REG_ADDR_W-1:0] writereg_m,
  input  logic [REG_ADDR_W-1:0] writereg_w,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  output logic                  fwd_a_d,
  output logic                  fwd_b_d,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e
);

  // ID compare operands can only be bypassed from MEM.
  always_comb begin
    fwd_a_d = regwrite_m && addr_hit(32'(writereg_m), 32'(rs_d));
    fwd_b_d = regwrite_m && addr_hit(32'(writereg_m), 32'(rt_d));
  end

  // EX operand A select; MEM holds the younger result so it wins over WB.
  always_comb begin
    fwd_a_e = FWD_RF;
    if (regwrite_m && addr_hit(32'(writereg_m), 32'(rs_e))) begin
      fwd_a_e = FWD_MEM;
    end else if (regwrite_w && addr_hit(32'(writereg_w), 32'(rs_e))) begin
      fwd_a_e = FWD_WB;
    end else begin
      fwd_a_e = FWD_RF;
    end
  end

  // EX operand B select, same priority as operand A.
  always_comb begin
    fwd_b_e = FWD_RF;
    if (regwrite_m && addr_hit(32'(writereg_m), 32'(rt_e))) begin
      fwd_b_e = FWD_MEM;
    end else if (regwrite_w && addr_hit(32'(writereg_w), 32'(rt_e))) begin
      fwd_b_e = FWD_WB;
    end else begin
      fwd_b_e = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage MIPS core. Drives stall
// (pipeline register en = ~stall_x) and flush (clc = flush_x) for every
// inter-stage register, selects operand forwarding, and sequences multi-cycle
// divides, aborting them on exceptions.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   rs_d, rt_d, rs_e, rt_e           : source registers in ID / EX
//   writereg_e/_m/_w, regwrite_e/_m/_w : destination register / write enable
//   memtoreg_e, memtoreg_m           : stage holds a load
//   branch_d                         : branch/jr resolving in ID
//   div_e, div_ready                 : divide in EX, divider result pulse
//   exception_m                      : exception taken in MEM
//   div_go, div_cancel               : start / abort the divider
//   stall_f, stall_d, stall_e        : hold PC, IF/ID, ID/EX
//   flush_d, flush_e, flush_m, flush_w : clear IF/ID, ID/EX, EX/MEM, MEM/WB
//   fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e : forwarding selects
//   stall_cnt                        : saturating count of cycles with stall_f
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rt_e,
  input  logic [REG_ADDR_W-1:0] writereg_e,
  input  logic [REG_ADDR_W-1:0] writereg_m,
  input  logic [REG_ADDR_W-1:0] writereg_w,
  input  logic                  regwrite_e,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  memtoreg_e,
  input  logic                  memtoreg_m,
  input  logic                  branch_d,
  input  logic                  div_e,
  input  logic                  div_ready,
  input  logic                  exception_m,
  output logic                  div_go,
  output logic                  div_cancel,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic                  flush_w,
  output logic                  fwd_a_d,
  output logic                  fwd_b_d,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic [CNT_W-1:0]      stall_cnt
);

  state_t           state_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             lwstall_s;
  logic             brstall_s;
  logic             launch_s;
  logic             divstall_s;

  fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd (
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .fwd_a_d    (fwd_a_d),
    .fwd_b_d    (fwd_b_d),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e)
  );

  // Hazard detection terms.
  always_comb begin
    // Load in EX feeding an ID source: one bubble until it reaches MEM.
    lwstall_s = memtoreg_e &&
                (addr_hit(32'(writereg_e), 32'(rs_d)) ||
                 addr_hit(32'(writereg_e), 32'(rt_d)));
    // Branch compares in ID need operands that are either still in EX, or a
    // load still in MEM (MEM bypass only covers ALU results).
    brstall_s = branch_d &&
                ((regwrite_e &&
                  (addr_hit(32'(writereg_e), 32'(rs_d)) ||
                   addr_hit(32'(writereg_e), 32'(rt_d)))) ||
                 (memtoreg_m &&
                  (addr_hit(32'(writereg_m), 32'(rs_d)) ||
                   addr_hit(32'(writereg_m), 32'(rt_d)))));
    // A divide in EX would launch this cycle if no exception intervenes.
    launch_s   = (state_r == IDLE) && div_e;
    divstall_s = launch_s || ((state_r == DIV_WAIT) && !div_ready);
  end

  // Stall/flush priority: reset > exception > divide > load/branch.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    flush_w    = 1'b0;
    div_go     = 1'b0;
    div_cancel = 1'b0;
    if (rst) begin
      // Divider shares this reset, so no cancel is needed here.
      div_cancel = 1'b0;
    end else if (exception_m) begin
      flush_d    = 1'b1;
      flush_e    = 1'b1;
      flush_m    = 1'b1;
      flush_w    = 1'b1;
      div_cancel = (state_r == DIV_WAIT) || launch_s;
    end else if (divstall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      div_go  = launch_s;
    end else if (lwstall_s || brstall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      div_go = 1'b0;
    end
  end

  // Divide sequencer; only IDLE can launch, so one divide launches once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (div_e && !exception_m) begin
            state_r <= DIV_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        DIV_WAIT: begin
          if (div_ready || exception_m) begin
            state_r <= IDLE;
          end else begin
            state_r <= DIV_WAIT;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which the front end is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_f && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic          regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic          branch_d, div_e, div_ready, exception_m;
  logic          div_go, div_cancel, stall_f, stall_d, stall_e;
  logic          flush_d, flush_e, flush_m, flush_w, fwd_a_d, fwd_b_d;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
    .div_e(div_e), .div_ready(div_ready), .exception_m(exception_m),
    .div_go(div_go), .div_cancel(div_cancel), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .flush_w(flush_w), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e),
    .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    stall;   // {f,d,e}
    logic [3:0]    flush;   // {d,e,m,w}
    logic          go;
    logic          cancel;
    logic [1:0]    fwd_d;   // {a,b}
    logic [1:0]    fae;
    logic [1:0]    fbe;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    writereg_e = '0; writereg_m = '0; writereg_w = '0;
    regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    memtoreg_e = 1'b0; memtoreg_m = 1'b0; branch_d = 1'b0;
    div_e = 1'b0; div_ready = 1'b0; exception_m = 1'b0;
  endtask

  // Inputs are already driven; push expectation, compare at negedge, advance.
  task automatic step(input string tag, input logic [2:0] st, input logic [3:0] fl,
                      input logic go, input logic cancel, input logic [1:0] fd,
                      input logic [1:0] fae, input logic [1:0] fbe);
    exp_t e;
    exp_t o;
    e.stall = st; e.flush = fl; e.go = go; e.cancel = cancel;
    e.fwd_d = fd; e.fae = fae; e.fbe = fbe; e.cnt = exp_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    check({tag, ".stall"},  32'({stall_f, stall_d, stall_e}), 32'(o.stall));
    check({tag, ".flush"},  32'({flush_d, flush_e, flush_m, flush_w}), 32'(o.flush));
    check({tag, ".div_go"}, 32'(div_go), 32'(o.go));
    check({tag, ".cancel"}, 32'(div_cancel), 32'(o.cancel));
    check({tag, ".fwd_d"},  32'({fwd_a_d, fwd_b_d}), 32'(o.fwd_d));
    check({tag, ".fwd_a_e"}, 32'(fwd_a_e), 32'(o.fae));
    check({tag, ".fwd_b_e"}, 32'(fwd_b_e), 32'(o.fbe));
    check({tag, ".cnt"},    32'(stall_cnt), 32'(o.cnt));
    if (rst) exp_cnt = '0;
    else if (o.stall[2] && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + CW'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'(dut.state_r), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; zero();
    @(posedge clk); #1;
    exp_cnt = '0;

    // Reset: forwarding still live, stalls suppressed even with hazards present
    regwrite_m = 1'b1; writereg_m = 5'd8; rs_e = 5'd8;
    memtoreg_e = 1'b1; writereg_e = 5'd9; rs_d = 5'd9; div_e = 1'b1;
    step("rst", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_MEM, FWD_RF);
    rst = 1'b0; zero();
    check_idle("rst_state");

    // EX forwarding priority and r0
    regwrite_m = 1'b1; writereg_m = 5'd8; rs_e = 5'd8; regwrite_w = 1'b1; writereg_w = 5'd8;
    step("fwd_mem", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_MEM, FWD_RF);
    regwrite_m = 1'b0;
    step("fwd_wb", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_WB, FWD_RF);
    regwrite_m = 1'b1; writereg_m = 5'd0; writereg_w = 5'd0; rs_e = 5'd0;
    step("fwd_r0", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    zero();
    regwrite_m = 1'b1; writereg_m = 5'd6; regwrite_w = 1'b1; writereg_w = 5'd5;
    rs_e = 5'd6; rt_e = 5'd5; rs_d = 5'd6; rt_d = 5'd5;
    step("fwd_mix", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b10, FWD_MEM, FWD_WB);

    // Load-use: one bubble
    zero(); memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd9; rs_d = 5'd9;
    step("lw", 3'b110, 4'b0100, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    zero(); memtoreg_m = 1'b1; regwrite_m = 1'b1; writereg_m = 5'd9; rs_d = 5'd9;
    step("lw_after", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b10, FWD_RF, FWD_RF);

    // Branch after load: two stall cycles, then MEM bypass
    zero(); branch_d = 1'b1; rt_d = 5'd10; regwrite_e = 1'b1; writereg_e = 5'd10;
    step("br_e", 3'b110, 4'b0100, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    zero(); branch_d = 1'b1; rt_d = 5'd10; memtoreg_m = 1'b1; regwrite_m = 1'b1; writereg_m = 5'd10;
    step("br_m", 3'b110, 4'b0100, 1'b0, 1'b0, 2'b01, FWD_RF, FWD_RF);
    zero(); branch_d = 1'b1; rt_d = 5'd10; regwrite_m = 1'b1; writereg_m = 5'd10;
    step("br_fwd", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b01, FWD_RF, FWD_RF);
    zero(); branch_d = 1'b1; memtoreg_e = 1'b1; regwrite_e = 1'b1;
    step("haz_r0", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);

    // Divide T..T+5; a load-use hazard underneath must not change outputs
    zero(); div_e = 1'b1;
    step("div_T", 3'b111, 4'b0010, 1'b1, 1'b0, 2'b00, FWD_RF, FWD_RF);
    check("div_state", 32'(dut.state_r), 32'(DIV_WAIT));
    for (int i = 1; i <= 4; i++) begin
      memtoreg_e = 1'b1; writereg_e = 5'd9; rs_d = 5'd9;
      step("div_wait", 3'b111, 4'b0010, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    end
    zero(); div_e = 1'b1; div_ready = 1'b1;
    step("div_rdy", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    check_idle("div_done_state");
    zero();
    step("div_after", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);

    // Exception at T+2 of a divide
    div_e = 1'b1;
    step("exd_T", 3'b111, 4'b0010, 1'b1, 1'b0, 2'b00, FWD_RF, FWD_RF);
    step("exd_T1", 3'b111, 4'b0010, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    exception_m = 1'b1;
    step("exd_T2", 3'b000, 4'b1111, 1'b0, 1'b1, 2'b00, FWD_RF, FWD_RF);
    check_idle("exd_state");
    zero();
    step("exd_T3", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);

    // div_ready and exception together: exception wins
    div_e = 1'b1;
    step("exr_T", 3'b111, 4'b0010, 1'b1, 1'b0, 2'b00, FWD_RF, FWD_RF);
    div_ready = 1'b1; exception_m = 1'b1;
    step("exr_T1", 3'b000, 4'b1111, 1'b0, 1'b1, 2'b00, FWD_RF, FWD_RF);
    check_idle("exr_state");

    // Exception while a launch would occur, and exception alone
    zero(); div_e = 1'b1; exception_m = 1'b1;
    step("exl", 3'b000, 4'b1111, 1'b0, 1'b1, 2'b00, FWD_RF, FWD_RF);
    check_idle("exl_state");
    zero(); exception_m = 1'b1; memtoreg_e = 1'b1; writereg_e = 5'd9; rs_d = 5'd9;
    step("exn", 3'b000, 4'b1111, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);

    // Reset mid-divide: no cancel, IDLE, counter cleared
    zero(); div_e = 1'b1;
    step("rsd_T", 3'b111, 4'b0010, 1'b1, 1'b0, 2'b00, FWD_RF, FWD_RF);
    rst = 1'b1;
    step("rsd_rst", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    check_idle("rsd_state");
    rst = 1'b0; zero();
    step("rsd_after", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);

    // Counter saturation
    memtoreg_e = 1'b1; writereg_e = 5'd9; rs_d = 5'd9;
    for (int i = 0; i < 18; i++) begin
      step("sat", 3'b110, 4'b0100, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    end
    zero();
    step("sat_hold", 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, FWD_RF, FWD_RF);
    check("cnt_sat", 32'(stall_cnt), 32'({CW{1'b1}}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It drives the stall (enable) and flush (clear) inputs of every inter-stage pipeline register and selects operand forwarding for ID and EX. It sequences multi-cycle divides through a small FSM and aborts them on exceptions. It sits beside the datapath; pipeline register `en` = ~`stall_x`, `clc` = `flush_x`.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rs_d, rt_d  in  REG_ADDR_W  source registers in ID
- rs_e, rt_e  in  REG_ADDR_W  source registers in EX
- writereg_e, writereg_m, writereg_w  in  REG_ADDR_W  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes register file
- memtoreg_e, memtoreg_m  in  1  stage is a load
- branch_d  in  1  branch/jr resolving in ID
- div_e  in  1  div/divu in EX
- div_ready  in  1  divider result valid, 1-cycle pulse
- exception_m  in  1  exception taken in MEM
- div_go  out  1  start divider, 1-cycle pulse
- div_cancel  out  1  abort divider
- stall_f, stall_d, stall_e  out  1  hold PC, IF/ID, ID/EX
- flush_d, flush_e, flush_m, flush_w  out  1  clear IF/ID, ID/EX, EX/MEM, MEM/WB
- fwd_a_d, fwd_b_d  out  1  ID compare operand from MEM result
- fwd_a_e, fwd_b_e  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- stall_cnt  out  CNT_W  cycles with stall_f=1, saturating

## Operation
- Register r0 never matches. Any comparison with address 0 is false.
- fwd_a_e is 10 if regwrite_m && writereg_m==rs_e. Otherwise it is 01 if regwrite_w && writereg_w==rs_e. Otherwise 00. MEM has priority over WB. fwd_b_e follows the same rule with rt_e.
- fwd_a_d = regwrite_m && writereg_m==rs_d. fwd_b_d follows the same rule with rt_d.
- lwstall = memtoreg_e && (writereg_e==rs_d || writereg_e==rt_d).
- brstall = branch_d && ((regwrite_e && writereg_e∈{rs_d,rt_d}) || (memtoreg_m && writereg_m∈{rs_d,rt_d})).
- FSM states: IDLE and DIV_WAIT.
  - IDLE → DIV_WAIT when div_e && !exception_m. div_go=1 in that cycle.
  - DIV_WAIT → IDLE when div_ready or exception_m.
  - DIV_WAIT is never re-entered from the same instruction, because launches occur only from IDLE.
- divstall = (IDLE && div_e) || (DIV_WAIT && !div_ready).
- Priority is exception > divide > load/branch:
  - exception_m: flush_d, flush_e, flush_m, flush_w all 1. All stalls 0. div_cancel=1 if the state is DIV_WAIT or a launch would occur. Next state is IDLE.
  - divstall: stall_f, stall_d, stall_e = 1. flush_m=1 (bubble into MEM).
  - lwstall|brstall: stall_f, stall_d = 1. flush_e=1 (bubble into EX).
- stall_cnt increments each cycle stall_f=1 and saturates at all-ones.

## Timing
- Forwarding and the stall/flush outputs are combinational from inputs and state, with zero latency.
- A divide launched at cycle T stalls EX from T. The stall drops in the cycle div_ready is seen, and the divide instruction advances at that edge.
- If div_ready and exception_m occur in the same cycle, the exception wins. div_cancel=1 and state goes to IDLE.
- A load-use hazard stalls for exactly 1 cycle. A branch after a load stalls for 2 cycles.
- While rst=1:
  - state IDLE, stall_cnt=0
  - all stall/flush/div_go/div_cancel outputs forced to 0
  - forwarding selects are still computed normally
- Reset mid-divide returns the FSM to IDLE without asserting div_cancel. The divider is reset by the same rst.

## Structure
- The shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - the state enum {IDLE, DIV_WAIT}
  - REG_ADDR_W default
- One sub-module: fwd_unit, the purely combinational forwarding logic for the ID and EX selects.
- The FSM, the stall/flush priority logic and stall_cnt stay in hazard_ctrl.

## Test plan
- regwrite_m=1, writereg_m=8, rs_e=8; regwrite_w=1, writereg_w=8 → fwd_a_e=10. Clear regwrite_m → 01. Set writereg=0 → 00.
- memtoreg_e=1, writereg_e=9, rs_d=9 → stall_f=stall_d=flush_e=1 for 1 cycle, stall_cnt +1.
- branch_d=1, rt_d=10, regwrite_e=1, writereg_e=10 → stall for 1 cycle. Next cycle memtoreg_m=1, writereg_m=10 → stall again. Then fwd_b_d=1.
- div_e=1 at T, div_ready at T+5 → div_go at T only. stall_e=1 and flush_m=1 for T..T+4. All stalls 0 at T+5. State IDLE at T+6.
- exception_m at T+2 of a divide → div_cancel=1, all four flushes 1, stalls 0, IDLE at T+3.
- rst asserted during DIV_WAIT → IDLE next cycle, outputs 0, stall_cnt=0. Also force stall_cnt saturation: it holds at 2^CNT_W−1.
